number_entry_reg: RTL and testbench

//  Multi-digit decimal entry register; parametrised successor of the single-code number latch.

---
 rtl/number_entry_reg.sv | 118 +++++++++++
 tb/tb_number_entry_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/number_entry_reg.sv
// number_entry_reg: multi-digit BCD entry register driven by PS/2 break codes
module number_entry_reg #(
    parameter int DIGITS = 4,
    parameter int CODE_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_W-1:0]     x,
    input  logic                  flag,
    output logic [4*DIGITS-1:0]   edit,
    output logic [3:0]            count,
    output logic [4*DIGITS-1:0]   number,
    output logic                  done,
    output logic                  overflow
);
    localparam int W = 4 * DIGITS;
    localparam logic [3:0] FULL_CNT = 4'(DIGITS);

    typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        edit_q, edit_d, number_q, number_d;
    logic [3:0]          count_q, count_d;
    logic                done_q, done_d, overflow_q, overflow_d, commit_q, commit_d;
    logic                flag_prev_q;
    logic [CODE_W-1:0]   x_last_q;
    logic                acc, brk, is_dig;
    logic [3:0]          dig;

    // a code is new when flag rises or the code word changes while flag stays high
    assign acc = flag & (~flag_prev_q | (x != x_last_q));
    assign brk = acc & (x[15:8] == 8'hF0);

    // scancode to digit map
    always_comb begin
        is_dig = 1'b1;
        dig    = 4'd0;
        case (x[7:0])
            8'h45: dig = 4'd0;
            8'h16: dig = 4'd1;
            8'h1E: dig = 4'd2;
            8'h26: dig = 4'd3;
            8'h25: dig = 4'd4;
            8'h2E: dig = 4'd5;
            8'h36: dig = 4'd6;
            8'h3D: dig = 4'd7;
            8'h3E: dig = 4'd8;
            8'h46: dig = 4'd9;
            default: is_dig = 1'b0;
        endcase
    end

    // edit/commit state machine next-state; commit_q delays done by one cycle after number moves
    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        count_d    = count_q;
        number_d   = number_q;
        overflow_d = overflow_q;
        commit_d   = 1'b0;
        done_d     = commit_q;
        if (brk) begin
            if (is_dig) begin
                if (state_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    edit_d  = W'({edit_q, dig});
                    count_d = count_q + 4'd1;
                    state_d = (count_q + 4'd1 == FULL_CNT) ? FULL : ENTRY;
                end
            end else if (x[7:0] == 8'h66) begin
                if (state_q != EMPTY) begin
                    edit_d  = edit_q >> 4;
                    count_d = count_q - 4'd1;
                    state_d = (count_q == 4'd1) ? EMPTY : ENTRY;
                end
            end else if (x[7:0] == 8'h5A || x[7:0] == 8'h76) begin
                number_d   = (x[7:0] == 8'h5A) ? edit_q : number_q;
                commit_d   = (x[7:0] == 8'h5A);
                edit_d     = '0;
                count_d    = 4'd0;
                overflow_d = 1'b0;
                state_d    = EMPTY;
            end
        end
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            edit_q      <= '0;
            count_q     <= 4'd0;
            number_q    <= '0;
            overflow_q  <= 1'b0;
            commit_q    <= 1'b0;
            done_q      <= 1'b0;
            flag_prev_q <= 1'b0;
            x_last_q    <= '0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            count_q     <= count_d;
            number_q    <= number_d;
            overflow_q  <= overflow_d;
            commit_q    <= commit_d;
            done_q      <= done_d;
            flag_prev_q <= flag;
            x_last_q    <= x;
        end
    end

    assign edit     = edit_q;
    assign count    = count_q;
    assign number   = number_q;
    assign done     = done_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_number_entry_reg.sv
// tb_number_entry_reg: randomized and directed checks against a digit-queue reference model
module tb_number_entry_reg;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;
    localparam int VW = 2 * W + 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   x = '0;
    logic          flag = 1'b0;
    logic [W-1:0]  edit, number;
    logic [3:0]    count;
    logic          done, overflow;

    int errs = 0;
    int checks = 0;

    logic [7:0] codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    int          q[$];
    logic [W-1:0] num_m;
    bit          ov_m, done_m, pend_m, fprev;
    logic [31:0] xprev;

    number_entry_reg #(.DIGITS(DIGITS), .CODE_W(32)) dut (
        .clk(clk), .reset(reset), .x(x), .flag(flag), .edit(edit), .count(count),
        .number(number), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] edit_m();
        int e = 0;
        foreach (q[i]) e = e * 16 + q[i];
        return W'(e);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {edit_m(), 4'(q.size()), num_m, done_m, ov_m};
    endfunction

    function automatic logic [31:0] code_of(int d);
        return {16'h0000, 8'hF0, codes[d]};
    endfunction

    task automatic model_reset();
        q.delete();
        num_m = '0; ov_m = 0; done_m = 0; pend_m = 0; fprev = 0; xprev = '0;
    endtask

    task automatic model_edge(input logic [31:0] c, input bit f);
        bit acc;
        int d;
        acc = f && (!fprev || c != xprev);
        d = -1;
        fprev = f;
        xprev = c;
        done_m = pend_m;
        pend_m = 0;
        if (acc && c[15:8] == 8'hF0) begin
            for (int i = 0; i < 10; i++) if (c[7:0] == codes[i]) d = i;
            if (d >= 0) begin
                if (q.size() == DIGITS) ov_m = 1; else q.push_back(d);
            end else if (c[7:0] == 8'h66) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (c[7:0] == 8'h5A) begin
                num_m = edit_m(); q.delete(); ov_m = 0; pend_m = 1;
            end else if (c[7:0] == 8'h76) begin
                q.delete(); ov_m = 0;
            end
        end
    endtask

    task automatic step(input logic [31:0] c, input bit f);
        @(negedge clk);
        x = c;
        flag = f;
        @(posedge clk);
        model_edge(c, f);
        #1;
    endtask

    task automatic press(input logic [31:0] c);
        step(c, 1);
        step(c, 0);
    endtask

    task automatic test_reset();
        reset = 1; x = 32'h0000F016; flag = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({edit, count, number, done, overflow} !== '0)
            begin errs++; $display("FAIL reset_state got=%h want=0", {edit, count, number, done, overflow}); end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            step(32'h0000F016, 1);
            checks++;
            if ({edit, count, number, done, overflow} !== exp_vec())
                begin errs++; $display("FAIL held_code cyc=%0d got=%h want=%h", i, {edit, count, number, done, overflow}, exp_vec()); end
        end
        checks++;
        if (edit !== 16'h0001 || count !== 4'd1)
            begin errs++; $display("FAIL single_event edit=%h count=%0d want 0001/1", edit, count); end
    endtask

    task automatic test_code_change();
        step(32'h0000F076, 1);
        step(32'h0000F016, 1);
        step(32'h0000F014, 1);
        step(32'h0000F016, 1);
        checks++;
        if (edit !== 16'h0011 || count !== 4'd2 || {edit, count, number, done, overflow} !== exp_vec())
            begin errs++; $display("FAIL code_change edit=%h count=%0d want 0011/2", edit, count); end
    endtask

    task automatic test_overflow();
        press(32'h0000F076);
        for (int d = 1; d <= 5; d++) press(code_of(d));
        checks++;
        if (edit !== 16'h1234 || count !== 4'd4 || overflow !== 1'b1)
            begin errs++; $display("FAIL overflow edit=%h count=%0d ov=%b want 1234/4/1", edit, count, overflow); end
        press(32'h0000F066);
        checks++;
        if (edit !== 16'h0123 || count !== 4'd3 || overflow !== 1'b1 || {edit, count, number, done, overflow} !== exp_vec())
            begin errs++; $display("FAIL backspace_full edit=%h count=%0d ov=%b want 0123/3/1", edit, count, overflow); end
    endtask

    task automatic test_commit();
        press(32'h0000F076);
        press(code_of(7));
        press(code_of(5));
        step(32'h0000F05A, 1);
        checks++;
        if (number !== 16'h0075 || done !== 1'b0 || edit !== '0 || count !== 4'd0 || overflow !== 1'b0)
            begin errs++; $display("FAIL commit_number number=%h done=%b edit=%h count=%0d want 0075/0/0/0", number, done, edit, count); end
        step(32'h0000F05A, 0);
        checks++;
        if (done !== 1'b1)
            begin errs++; $display("FAIL commit_done got=%b want=1", done); end
        step(32'h0000F05A, 0);
        checks++;
        if (done !== 1'b0 || {edit, count, number, done, overflow} !== exp_vec())
            begin errs++; $display("FAIL commit_done_drop got=%b want=0", done); end
    endtask

    task automatic test_escape();
        press(code_of(9));
        checks++;
        if (edit !== 16'h0009)
            begin errs++; $display("FAIL escape_pre edit=%h want=0009", edit); end
        step(32'h0000F076, 1);
        checks++;
        if (edit !== '0 || count !== 4'd0 || number !== 16'h0075 || done !== 1'b0)
            begin errs++; $display("FAIL escape edit=%h number=%h done=%b want 0/0075/0", edit, number, done); end
        step(32'h0000F076, 0);
        checks++;
        if (done !== 1'b0)
            begin errs++; $display("FAIL escape_nodone got=%b want=0", done); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        logic [3:0] want;
        press(code_of(2));
        step(32'h0000F05A, 1); seen[3] = done;
        step(32'h00000000, 0); seen[2] = done;
        step(32'h0000F05A, 1); seen[1] = done;
        step(32'h00000000, 0); seen[0] = done;
        want = 4'b0101;
        checks++;
        if (seen !== want || number !== 16'h0000)
            begin errs++; $display("FAIL back_to_back done_seq=%b want=%b number=%h want=0000", seen, want, number); end
    endtask

    task automatic test_no_prefix();
        press(32'h0000F076);
        step(32'h00000016, 1);
        checks++;
        if (edit !== '0 || count !== 4'd0 || {edit, count, number, done, overflow} !== exp_vec())
            begin errs++; $display("FAIL no_prefix edit=%h count=%0d want 0/0", edit, count); end
        step(32'h00000016, 0);
    endtask

    task automatic test_random();
        logic [31:0] c;
        int r;
        c = '0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 6) c = code_of($urandom_range(0, 9));
            else if (r == 7) c = 32'h0000F066;
            else if (r == 8) c = 32'h0000F05A;
            else if (r == 9) c = 32'h0000F076;
            else if (r == 10) c = {($urandom_range(0, 1) != 0) ? 16'hA5A5 : 16'h0000,
                                   ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0, 8'($urandom())};
            step(c, $urandom_range(0, 9) < 7);
            checks++;
            if ({edit, count, number, done, overflow} !== exp_vec())
                begin errs++; $display("FAIL random i=%0d x=%h got=%h want=%h", i, c, {edit, count, number, done, overflow}, exp_vec()); end
        end
    endtask

    task automatic test_async_reset();
        press(32'h0000F076);
        press(code_of(3));
        press(code_of(4));
        press(32'h0000F05A);
        press(code_of(8));
        checks++;
        if (count !== 4'd1 || number !== 16'h0034)
            begin errs++; $display("FAIL pre_async count=%0d number=%h want 1/0034", count, number); end
        #2;
        reset = 1;
        #1;
        checks++;
        if ({edit, count, number, done, overflow} !== '0)
            begin errs++; $display("FAIL async_reset got=%h want=0", {edit, count, number, done, overflow}); end
        model_reset();
        @(negedge clk);
        reset = 0;
        step(code_of(6), 1);
        checks++;
        if (edit !== 16'h0006 || count !== 4'd1)
            begin errs++; $display("FAIL after_reset edit=%h count=%0d want 0006/1", edit, count); end
    endtask

    initial begin
        test_reset();
        test_code_change();
        test_overflow();
        test_commit();
        test_escape();
        test_back_to_back();
        test_no_prefix();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
